// File: rtl/fcb_cwf_pkg.sv
// Shared types and widths for the FRFU config-word packer.
// Lane encoding and byte/word sizes used by the packer and its FIFO.
package fcb_cwf_pkg;

    localparam int CWF_BYTE_W = 8;
    localparam int CWF_WORD_W = 32;

    typedef enum logic [1:0] {
        LANE0,
        LANE1,
        LANE2,
        LANE3
    } EN_LANE;

endpackage

// File: rtl/fcb_cwf_sfifo.sv
// Single-clock first-word-fall-through FIFO of 32-bit config words.
// Read data holds the last popped word while the FIFO is empty.
module fcb_cwf_sfifo
    import fcb_cwf_pkg::*;
#(
    parameter int PAR_DEPTH = 8,
    parameter int PAR_AW    = $clog2(PAR_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [CWF_WORD_W-1:0] wdata,
    output logic [CWF_WORD_W-1:0] rdata,
    output logic [PAR_AW:0]       cnt,
    output logic                  full,
    output logic                  empty
);

    logic [CWF_WORD_W-1:0] mem [PAR_DEPTH];
    logic [CWF_WORD_W-1:0] last_q;
    logic [PAR_AW-1:0]     wr_ptr;
    logic [PAR_AW-1:0]     rd_ptr;
    logic                  pop_ok;
    logic                  push_ok;

    assign full    = (cnt == (PAR_AW+1)'(PAR_DEPTH));
    assign empty   = (cnt == '0);
    assign pop_ok  = pop & ~empty & ~flush;
    assign push_ok = push & ~flush & (~full | pop_ok);
    assign rdata   = empty ? last_q : mem[rd_ptr];

    // Storage array, written at the tail on every accepted push.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers, occupancy and the word shown once the FIFO drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            last_q <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
                last_q <= mem[rd_ptr];
            end
            if (push_ok && !pop_ok) begin
                cnt <= cnt + 1'b1;
            end else if (pop_ok && !push_ok) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fcb_cwf_packer.sv
// Packs the SPI config byte stream little-endian into 32-bit words.
// Completed words go to a FWFT FIFO; words with no room are dropped.
module fcb_cwf_packer
    import fcb_cwf_pkg::*;
#(
    parameter int PAR_DEPTH = 8,
    parameter int PAR_AW    = $clog2(PAR_DEPTH)
) (
    input  logic                  fcb_sys_clk,
    input  logic                  fcb_sys_rst,
    input  logic                  fssc_frfu_cwf_wr_en,
    input  logic [CWF_BYTE_W-1:0] fssc_frfu_cwf_wr_data,
    input  logic                  fcwf_flush,
    input  logic                  fcwf_rd_en,
    input  logic                  fcwf_ovf_clr,
    output logic [CWF_WORD_W-1:0] fcwf_rd_data,
    output logic                  fcwf_empty,
    output logic                  frfu_cwf_full,
    output logic [PAR_AW:0]       fcwf_word_cnt,
    output logic                  fcwf_overflow
);

    EN_LANE                lane_q;
    EN_LANE                lane_d;
    logic [23:0]           asm_q;
    logic [23:0]           asm_d;
    logic                  ovf_q;
    logic                  ovf_d;
    logic                  push;
    logic                  slot;
    logic [CWF_WORD_W-1:0] word;

    assign slot          = ~frfu_cwf_full | (fcwf_rd_en & ~fcwf_empty);
    assign word          = {fssc_frfu_cwf_wr_data, asm_q};
    assign fcwf_overflow = ovf_q;

    // Lane state, partial word and sticky overflow registers.
    always_ff @(posedge fcb_sys_clk or posedge fcb_sys_rst) begin
        if (fcb_sys_rst) begin
            lane_q <= LANE0;
            asm_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            lane_q <= lane_d;
            asm_q  <= asm_d;
            ovf_q  <= ovf_d;
        end
    end

    // Byte placement, word commit and overflow detection.
    always_comb begin
        lane_d = lane_q;
        asm_d  = asm_q;
        ovf_d  = ovf_q;
        push   = 1'b0;
        if (fcwf_ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (fcwf_flush) begin
            lane_d = LANE0;
            asm_d  = '0;
        end else if (fssc_frfu_cwf_wr_en) begin
            unique case (lane_q)
                LANE0: begin
                    asm_d[7:0] = fssc_frfu_cwf_wr_data;
                    lane_d     = LANE1;
                end
                LANE1: begin
                    asm_d[15:8] = fssc_frfu_cwf_wr_data;
                    lane_d      = LANE2;
                end
                LANE2: begin
                    asm_d[23:16] = fssc_frfu_cwf_wr_data;
                    lane_d       = LANE3;
                end
                LANE3: begin
                    lane_d = LANE0;
                    if (slot) begin
                        push = 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            endcase
        end
    end

    fcb_cwf_sfifo #(
        .PAR_DEPTH(PAR_DEPTH),
        .PAR_AW   (PAR_AW)
    ) u_fifo (
        .clk  (fcb_sys_clk),
        .rst  (fcb_sys_rst),
        .push (push),
        .pop  (fcwf_rd_en),
        .flush(fcwf_flush),
        .wdata(word),
        .rdata(fcwf_rd_data),
        .cnt  (fcwf_word_cnt),
        .full (frfu_cwf_full),
        .empty(fcwf_empty)
    );

endmodule

// File: tb/tb_fcb_cwf_packer.sv
// Directed bench for the config-word packer.
// Expected words are hand-derived little-endian byte packings.
module tb_fcb_cwf_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_data = '0;
    logic        flush = 1'b0;
    logic        rd_en = 1'b0;
    logic        ovf_clr = 1'b0;
    logic [31:0] rd_data;
    logic        empty;
    logic        full;
    logic [3:0]  cnt;
    logic        ovf;

    int n_run = 0;
    int n_fail = 0;

    logic [31:0] exp_q [8];

    fcb_cwf_packer #(.PAR_DEPTH(8)) dut (
        .fcb_sys_clk          (clk),
        .fcb_sys_rst          (rst),
        .fssc_frfu_cwf_wr_en  (wr_en),
        .fssc_frfu_cwf_wr_data(wr_data),
        .fcwf_flush           (flush),
        .fcwf_rd_en           (rd_en),
        .fcwf_ovf_clr         (ovf_clr),
        .fcwf_rd_data         (rd_data),
        .fcwf_empty           (empty),
        .frfu_cwf_full        (full),
        .fcwf_word_cnt        (cnt),
        .fcwf_overflow        (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic put(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_cnt", 32'(cnt), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_data", rd_data, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        put(8'h11); put(8'h22); put(8'h33);
        chk("w1_pre_empty", 32'(empty), 32'd1);
        put(8'h44);
        chk("w1_empty", 32'(empty), 32'd0);
        chk("w1_data", rd_data, 32'h44332211);
        chk("w1_cnt", 32'(cnt), 32'd1);
        pop();
        chk("w1_pop_empty", 32'(empty), 32'd1);
        chk("w1_pop_cnt", 32'(cnt), 32'd0);

        for (int i = 0; i < 32; i++) put(8'(i));
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_cnt", 32'(cnt), 32'd8);
        chk("fill_head", rd_data, 32'h03020100);
        chk("fill_ovf", 32'(ovf), 32'd0);

        put(8'hAA); put(8'hBB); put(8'hCC); put(8'hDD);
        chk("ovf_set", 32'(ovf), 32'd1);
        chk("ovf_cnt", 32'(cnt), 32'd8);
        chk("ovf_head", rd_data, 32'h03020100);
        chk("ovf_lane", 32'(dut.lane_q), 32'd0);
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
        chk("ovf_clr", 32'(ovf), 32'd0);

        put(8'h0A); put(8'h0B); put(8'h0C);
        rd_en = 1'b1;
        put(8'h0D);
        rd_en = 1'b0;
        chk("pp_cnt", 32'(cnt), 32'd8);
        chk("pp_ovf", 32'(ovf), 32'd0);
        chk("pp_head", rd_data, 32'h07060504);

        for (int i = 0; i < 7; i++)
            exp_q[i] = {8'(4*i+7), 8'(4*i+6), 8'(4*i+5), 8'(4*i+4)};
        exp_q[7] = 32'h0D0C0B0A;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d", i), rd_data, exp_q[i]);
            pop();
        end
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_hold", rd_data, 32'h0D0C0B0A);
        pop();
        chk("ign_cnt", 32'(cnt), 32'd0);
        chk("ign_empty", 32'(empty), 32'd1);

        put(8'h55); put(8'h66);
        flush = 1'b1;
        put(8'h77);
        flush = 1'b0;
        chk("fl_cnt0", 32'(cnt), 32'd0);
        put(8'h01); put(8'h02); put(8'h03); put(8'h04);
        chk("fl_data", rd_data, 32'h04030201);
        chk("fl_cnt", 32'(cnt), 32'd1);

        put(8'h99); put(8'h98);
        #3;
        rst = 1'b1;
        #1;
        chk("ar_cnt", 32'(cnt), 32'd0);
        chk("ar_empty", 32'(empty), 32'd1);
        chk("ar_data", rd_data, 32'h0);
        chk("ar_ovf", 32'(ovf), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        put(8'hDE); put(8'hAD); put(8'hBE); put(8'hEF);
        chk("ar_word", rd_data, 32'hEFBEADDE);
        chk("ar_wcnt", 32'(cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
